// File: rtl/kb_event_decoder_pkg.sv
// Shared constants, event layout and FSM
// encoding for the keyboard event decoder.
package kb_pkg;

  localparam logic [7:0] KB_EXT    = 8'hE0;
  localparam logic [7:0] KB_BRK    = 8'hF0;
  localparam logic [7:0] KB_LSHIFT = 8'h12;
  localparam logic [7:0] KB_RSHIFT = 8'h59;
  localparam logic [7:0] KB_CTRL   = 8'h14;
  localparam logic [7:0] KB_ALT    = 8'h11;

  localparam int EV_W   = 10;
  localparam int EV_BRK = 9;
  localparam int EV_EXT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_e;

  function automatic logic is_prefix(
    input logic [7:0] code
  );
    return (code == KB_EXT) ||
           (code == KB_BRK);
  endfunction

endpackage

// File: rtl/kb_event_decoder_if.sv
// Scan-byte input, event FIFO read side and
// status outputs of the keyboard decoder.
interface kb_event_decoder_if;
  logic       scan_tick;
  logic [7:0] scan_code;
  logic       rd_ev;
  logic [9:0] ev_data;
  logic       ev_empty;
  logic       ev_full;
  logic       shift_dn;
  logic       ctrl_dn;
  logic       alt_dn;
  logic       proto_err;
  logic       ovf_tick;

  modport master (
    output scan_tick, scan_code, rd_ev,
    input  ev_data, ev_empty, ev_full,
    input  shift_dn, ctrl_dn, alt_dn,
    input  proto_err, ovf_tick
  );

  modport slave (
    input  scan_tick, scan_code, rd_ev,
    output ev_data, ev_empty, ev_full,
    output shift_dn, ctrl_dn, alt_dn,
    output proto_err, ovf_tick
  );
endinterface

// File: rtl/kb_event_fifo.sv
// First-word-fall-through event FIFO with
// registered full/empty flags.
module kb_event_fifo #(
  parameter int B = 10,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_i,
  input  logic [B-1:0] wr_data_i,
  input  logic         rd_i,
  output logic [B-1:0] rd_data_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         drop_o
);

  logic [B-1:0] mem_q [2**W];
  logic [W-1:0] wr_ptr_q;
  logic [W-1:0] rd_ptr_q;
  logic [W-1:0] wr_ptr_d;
  logic [W-1:0] rd_ptr_d;
  logic         empty_q;
  logic         full_q;
  logic         do_rd;
  logic         do_wr;

  assign do_rd    = rd_i & ~empty_q;
  assign do_wr    = wr_i & (~full_q | do_rd);
  assign wr_ptr_d = wr_ptr_q + W'(1);
  assign rd_ptr_d = rd_ptr_q + W'(1);

  assign rd_data_o = empty_q ? '0
                             : mem_q[rd_ptr_q];
  assign empty_o   = empty_q;
  assign full_o    = full_q;
  assign drop_o    = wr_i & ~do_wr;

  // Storage array; contents masked while empty
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and occupancy flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_d;
      if (do_rd) rd_ptr_q <= rd_ptr_d;
      unique case ({do_wr, do_rd})
        2'b10: begin
          empty_q <= 1'b0;
          full_q  <= (wr_ptr_d == rd_ptr_q);
        end
        2'b01: begin
          full_q  <= 1'b0;
          empty_q <= (rd_ptr_d == wr_ptr_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/kb_event_decoder.sv
// PS/2 scan-sequence decoder: make/break
// events, modifier state, event FIFO.
module kb_event_decoder
  import kb_pkg::*;
#(
  parameter int FIFO_AW     = 2,
  parameter int MAKE_EN     = 1,
  parameter int BRK_EN      = 1,
  parameter int REPEAT_FILT = 0
) (
  input  logic               clk,
  input  logic               reset,
  kb_event_decoder_if.slave  kb
);

  kb_state_e       st_q;
  kb_state_e       st_d;
  logic            mk;
  logic            bk;
  logic            ext;
  logic            err;
  logic [8:0]      key;
  logic [EV_W-1:0] ev;
  logic            supp;
  logic            wr;
  logic            drop;
  logic [8:0]      last_q;
  logic            last_vld_q;
  logic            perr_q;
  logic            ovf_q;
  logic            lsh_q;
  logic            rsh_q;
  logic            lctl_q;
  logic            rctl_q;
  logic            lalt_q;
  logic            ralt_q;

  assign key = {ext, kb.scan_code};

  // Prefix decode for the current byte
  always_comb begin
    st_d = st_q;
    mk   = 1'b0;
    bk   = 1'b0;
    ext  = 1'b0;
    err  = 1'b0;
    if (kb.scan_tick) begin
      unique case (st_q)
        ST_IDLE: begin
          if (kb.scan_code == KB_EXT)
            st_d = ST_EXT;
          else if (kb.scan_code == KB_BRK)
            st_d = ST_BRK;
          else
            mk = 1'b1;
        end
        ST_EXT: begin
          ext = 1'b1;
          if (kb.scan_code == KB_BRK)
            st_d = ST_EXT_BRK;
          else if (kb.scan_code != KB_EXT) begin
            mk   = 1'b1;
            st_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          st_d = ST_IDLE;
          err  = is_prefix(kb.scan_code);
          bk   = ~err;
        end
        default: begin
          ext  = 1'b1;
          st_d = ST_IDLE;
          err  = is_prefix(kb.scan_code);
          bk   = ~err;
        end
      endcase
    end
  end

  // Event word and enqueue qualification
  always_comb begin
    ev           = '0;
    ev[EV_BRK]   = bk;
    ev[EV_EXT]   = ext;
    ev[7:0]      = kb.scan_code;
    supp = (REPEAT_FILT != 0) & mk &
           last_vld_q & (last_q == key);
    wr   = (mk & (MAKE_EN != 0) & ~supp) |
           (bk & (BRK_EN != 0));
  end

  // Decode FSM with registered pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= ST_IDLE;
      perr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      perr_q <= err;
      ovf_q  <= drop;
    end
  end

  // Last make seen, for typematic filtering
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (mk) begin
      last_q     <= key;
      last_vld_q <= 1'b1;
    end else if (bk) begin
      last_vld_q <= 1'b0;
    end
  end

  // Left/right modifier flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lsh_q  <= 1'b0;
      rsh_q  <= 1'b0;
      lctl_q <= 1'b0;
      rctl_q <= 1'b0;
      lalt_q <= 1'b0;
      ralt_q <= 1'b0;
    end else if (mk | bk) begin
      unique case (key)
        {1'b0, KB_LSHIFT}: lsh_q  <= mk;
        {1'b0, KB_RSHIFT}: rsh_q  <= mk;
        {1'b0, KB_CTRL}:   lctl_q <= mk;
        {1'b1, KB_CTRL}:   rctl_q <= mk;
        {1'b0, KB_ALT}:    lalt_q <= mk;
        {1'b1, KB_ALT}:    ralt_q <= mk;
        default: ;
      endcase
    end
  end

  kb_event_fifo #(
    .B (EV_W),
    .W (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_i      (wr),
    .wr_data_i (ev),
    .rd_i      (kb.rd_ev),
    .rd_data_o (kb.ev_data),
    .empty_o   (kb.ev_empty),
    .full_o    (kb.ev_full),
    .drop_o    (drop)
  );

  assign kb.shift_dn  = lsh_q | rsh_q;
  assign kb.ctrl_dn   = lctl_q | rctl_q;
  assign kb.alt_dn    = lalt_q | ralt_q;
  assign kb.proto_err = perr_q;
  assign kb.ovf_tick  = ovf_q;

endmodule

// File: tb/tb_kb_event_decoder.sv
// Self-checking bench: directed scenarios plus
// random byte streams against a queue model.
module tb_kb_event_decoder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  kb_event_decoder_if ifa ();
  kb_event_decoder_if ifb ();

  kb_event_decoder #(
    .FIFO_AW(2), .MAKE_EN(1),
    .BRK_EN(1), .REPEAT_FILT(0)
  ) dut_a (
    .clk(clk), .reset(reset), .kb(ifa)
  );

  kb_event_decoder #(
    .FIFO_AW(2), .MAKE_EN(1),
    .BRK_EN(1), .REPEAT_FILT(1)
  ) dut_b (
    .clk(clk), .reset(reset), .kb(ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per instance an event
  // queue (head at index 0), prefix flags,
  // set of held keys and last-make memory.
  localparam int DEPTH = 4;
  logic [9:0] mq [2][DEPTH];
  int         mcnt [2];
  bit         mext [2];
  bit         mbrk [2];
  bit         mheld [2][512];
  logic [8:0] mlast [2];
  bit         mlv [2];
  bit         mperr [2];
  bit         movf [2];
  bit         mrf [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i]  = 0;
      mext[i]  = 0;
      mbrk[i]  = 0;
      mlv[i]   = 0;
      mlast[i] = '0;
      mperr[i] = 0;
      movf[i]  = 0;
      for (int k = 0; k < 512; k++)
        mheld[i][k] = 0;
    end
    mrf[0] = 0;
    mrf[1] = 1;
  endtask

  task automatic model_step(
    input int i, input bit t,
    input logic [7:0] c, input bit r
  );
    bit emit, isbrk, enq;
    logic [8:0] key;
    emit = 0; isbrk = 0; enq = 0; key = '0;
    mperr[i] = 0;
    movf[i]  = 0;
    if (r && mcnt[i] > 0) begin
      for (int k = 0; k < DEPTH - 1; k++)
        mq[i][k] = mq[i][k+1];
      mcnt[i]--;
    end
    if (t) begin
      if (c == 8'hE0 || c == 8'hF0) begin
        if (mbrk[i]) begin
          mperr[i] = 1;
          mbrk[i]  = 0;
          mext[i]  = 0;
        end else if (c == 8'hE0)
          mext[i] = 1;
        else
          mbrk[i] = 1;
      end else begin
        emit  = 1;
        isbrk = mbrk[i];
        key   = {mext[i], c};
        mbrk[i] = 0;
        mext[i] = 0;
      end
    end
    if (emit && !isbrk) begin
      mheld[i][key] = 1;
      enq = !(mrf[i] && mlv[i] &&
              mlast[i] == key);
      mlast[i] = key;
      mlv[i]   = 1;
    end else if (emit) begin
      mheld[i][key] = 0;
      mlv[i] = 0;
      enq    = 1;
    end
    if (enq) begin
      if (mcnt[i] < DEPTH) begin
        mq[i][mcnt[i]] = {isbrk, key};
        mcnt[i]++;
      end else
        movf[i] = 1;
    end
  endtask

  function automatic logic [16:0] exp_out(
    input int i
  );
    logic [9:0] d;
    d = (mcnt[i] > 0) ? mq[i][0] : 10'h0;
    return {d, mcnt[i] == 0,
            mcnt[i] == DEPTH,
            mheld[i][9'h012] | mheld[i][9'h059],
            mheld[i][9'h014] | mheld[i][9'h114],
            mheld[i][9'h011] | mheld[i][9'h111],
            mperr[i], movf[i]};
  endfunction

  function automatic logic [16:0] obs_out(
    input int i
  );
    if (i == 0)
      return {ifa.ev_data, ifa.ev_empty,
              ifa.ev_full, ifa.shift_dn,
              ifa.ctrl_dn, ifa.alt_dn,
              ifa.proto_err, ifa.ovf_tick};
    return {ifb.ev_data, ifb.ev_empty,
            ifb.ev_full, ifb.shift_dn,
            ifb.ctrl_dn, ifb.alt_dn,
            ifb.proto_err, ifb.ovf_tick};
  endfunction

  task automatic set_in(
    input bit t, input logic [7:0] c,
    input bit r
  );
    ifa.scan_tick = t;
    ifa.scan_code = c;
    ifa.rd_ev     = r;
    ifb.scan_tick = t;
    ifb.scan_code = c;
    ifb.rd_ev     = r;
  endtask

  // Called at a negedge; one clock, returns at
  // the next negedge with inputs idle.
  task automatic drive(
    input bit t, input logic [7:0] c,
    input bit r
  );
    set_in(t, c, r);
    @(posedge clk);
    model_step(0, t, c, r);
    model_step(1, t, c, r);
    @(negedge clk);
    set_in(0, 8'h00, 0);
  endtask

  task automatic do_reset();
    set_in(0, 8'h00, 0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs_out(0) !== {10'h0, 7'b1000000}) begin
      n_bad++;
      $display("FAIL reset_state got %h want %h",
               obs_out(0), {10'h0, 7'b1000000});
    end
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 8'h1C, 0);
    n_cmp++;
    if (ifa.ev_empty !== 1'b0 ||
        ifa.ev_data !== 10'h01C) begin
      n_bad++;
      $display("FAIL basic_make got e=%b d=%h want e=0 d=01c",
               ifa.ev_empty, ifa.ev_data);
    end
    drive(1, 8'hF0, 0);
    drive(1, 8'h1C, 0);
    drive(0, 8'h00, 1);
    n_cmp++;
    if (ifa.ev_data !== 10'h21C) begin
      n_bad++;
      $display("FAIL basic_break got %h want 21c",
               ifa.ev_data);
    end
    drive(0, 8'h00, 1);
    n_cmp++;
    if (ifa.ev_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_drain got e=%b want 1",
               ifa.ev_empty);
    end
  endtask

  task automatic test_extended();
    do_reset();
    drive(1, 8'hE0, 0);
    drive(1, 8'h75, 0);
    drive(1, 8'hE0, 0);
    drive(1, 8'hF0, 0);
    drive(1, 8'h75, 0);
    n_cmp++;
    if (ifa.ev_data !== 10'h175 ||
        {ifa.shift_dn, ifa.ctrl_dn,
         ifa.alt_dn} !== 3'b000) begin
      n_bad++;
      $display("FAIL ext_make got %h mods=%b want 175 mods=000",
               ifa.ev_data, {ifa.shift_dn,
               ifa.ctrl_dn, ifa.alt_dn});
    end
    drive(0, 8'h00, 1);
    n_cmp++;
    if (ifa.ev_data !== 10'h375) begin
      n_bad++;
      $display("FAIL ext_break got %h want 375",
               ifa.ev_data);
    end
  endtask

  task automatic test_modifiers();
    logic [7:0] seq [9];
    bit         sh  [9];
    seq = '{8'h12, 8'h59, 8'hF0, 8'h12,
            8'hF0, 8'h59, 8'hE0, 8'h14, 8'h11};
    sh  = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1, seq[k], 1);
      n_cmp++;
      if (ifa.shift_dn !== sh[k]) begin
        n_bad++;
        $display("FAIL shift_step%0d got %b want %b",
                 k, ifa.shift_dn, sh[k]);
      end
    end
    n_cmp++;
    if ({ifa.ctrl_dn, ifa.alt_dn} !== 2'b11) begin
      n_bad++;
      $display("FAIL ctrl_alt got %b want 11",
               {ifa.ctrl_dn, ifa.alt_dn});
    end
  endtask

  task automatic test_overflow();
    int ovf_seen;
    logic [9:0] want [4];
    want = '{10'h016, 10'h017,
             10'h018, 10'h033};
    ovf_seen = 0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1, 8'(8'h15 + k), 0);
      ovf_seen += int'(ifa.ovf_tick);
    end
    n_cmp++;
    if (ovf_seen != 2 || ifa.ev_full !== 1'b1 ||
        ifa.ev_data !== 10'h015) begin
      n_bad++;
      $display("FAIL ovf_fill got ovf=%0d f=%b d=%h want 2 1 015",
               ovf_seen, ifa.ev_full, ifa.ev_data);
    end
    drive(1, 8'h33, 1);
    n_cmp++;
    if (ifa.ovf_tick !== 1'b0 ||
        ifa.ev_full !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_rdwr got ovf=%b f=%b want 0 1",
               ifa.ovf_tick, ifa.ev_full);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (ifa.ev_data !== want[k]) begin
        n_bad++;
        $display("FAIL ovf_order%0d got %h want %h",
                 k, ifa.ev_data, want[k]);
      end
      drive(0, 8'h00, 1);
    end
  endtask

  task automatic test_repeat();
    logic [7:0] seq [6];
    logic [9:0] want [3];
    seq  = '{8'h1C, 8'h1C, 8'h1C,
             8'hF0, 8'h1C, 8'h1C};
    want = '{10'h01C, 10'h21C, 10'h01C};
    do_reset();
    foreach (seq[k]) drive(1, seq[k], 0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ifb.ev_empty !== 1'b0 ||
          ifb.ev_data !== want[k]) begin
        n_bad++;
        $display("FAIL repeat_ev%0d got e=%b d=%h want %h",
                 k, ifb.ev_empty, ifb.ev_data, want[k]);
      end
      drive(0, 8'h00, 1);
    end
    n_cmp++;
    if (ifb.ev_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL repeat_extra got e=%b want 1",
               ifb.ev_empty);
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    drive(1, 8'hF0, 0);
    drive(1, 8'hF0, 0);
    n_cmp++;
    if (ifa.proto_err !== 1'b1 ||
        ifa.ev_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL perr_pulse got p=%b e=%b want 1 1",
               ifa.proto_err, ifa.ev_empty);
    end
    drive(0, 8'h00, 0);
    n_cmp++;
    if (ifa.proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL perr_width got %b want 0",
               ifa.proto_err);
    end
  endtask

  task automatic test_reset_mid_seq();
    do_reset();
    drive(1, 8'hE0, 0);
    do_reset();
    drive(1, 8'h1C, 0);
    n_cmp++;
    if (ifa.ev_data !== 10'h01C) begin
      n_bad++;
      $display("FAIL reset_prefix got %h want 01c",
               ifa.ev_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] mods [4];
    bit t, r;
    logic [7:0] c;
    int sel;
    mods = '{8'h12, 8'h59, 8'h14, 8'h11};
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      t   = ($urandom_range(0, 9) < 6);
      r   = ($urandom_range(0, 9) < 3);
      sel = int'($urandom_range(0, 19));
      if (sel < 3)       c = 8'hE0;
      else if (sel < 7)  c = 8'hF0;
      else if (sel < 13) c = mods[sel % 4];
      else if (sel < 16) c = 8'h1C;
      else c = 8'($urandom_range(0, 255));
      drive(t, c, r);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs_out(i) !== exp_out(i)) begin
          n_bad++;
          $display("FAIL random%0d inst%0d got %h want %h",
                   n, i, obs_out(i), exp_out(i));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 8'h00, 0);
    model_reset();
    test_reset();
    test_basic();
    test_extended();
    test_modifiers();
    test_overflow();
    test_repeat();
    test_proto_err();
    test_reset_mid_seq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kb_event_decoder.md
Name: kb_event_decoder

Overview:
Parametrised successor to the single-code keyboard front end. It consumes byte ticks from the existing PS/2 receiver and decodes full scan-code sequences, including E0-extended keys and F0 break prefixes. Each decoded key is a make or break event, buffered in a configurable-depth FIFO for the CPU-side reader. The block also tracks live Shift/Ctrl/Alt modifier state and reports protocol errors and FIFO overflow.

Parameters:
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.
MAKE_EN, 1, 1 = enqueue make events; 0 = discard them.
BRK_EN, 1, 1 = enqueue break events; 0 = discard them.
REPEAT_FILT, 0, 1 = suppress typematic repeats (make identical to last make, with no break in between).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
scan_tick  in  1  one-cycle pulse; scan_code valid
scan_code  in  8  received PS/2 byte
rd_ev  in  1  pop head event (ignored when empty)
ev_data  out  10  head event: [9]=break, [8]=extended, [7:0]=code; first-word-fall-through
ev_empty  out  1  FIFO empty
ev_full  out  1  FIFO full
shift_dn  out  1  either shift held (12 or 59)
ctrl_dn  out  1  either ctrl held (14, E0 14)
alt_dn  out  1  either alt held (11, E0 11)
proto_err  out  1  one-cycle pulse on an illegal prefix sequence
ovf_tick  out  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset: FSM goes to IDLE. FIFO empties: ev_empty=1, ev_full=0, ev_data=0. All modifiers=0, proto_err=0, ovf_tick=0. The last-make register is cleared and marked invalid. Reset mid-sequence discards any partial prefix.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Only cycles with scan_tick=1 advance the FSM.
- IDLE: E0 -> EXT. F0 -> BRK. Any other byte -> emit make, ext=0, stay IDLE.
- EXT: F0 -> EXT_BRK. E0 -> stay EXT, no error. Other byte -> emit make, ext=1, go IDLE.
- BRK: E0 or F0 -> pulse proto_err, go IDLE, emit nothing. Other byte -> emit break, ext=0, go IDLE.
- EXT_BRK: E0 or F0 -> pulse proto_err, go IDLE. Other byte -> emit break, ext=1, go IDLE.
- E1 (Pause) and all other bytes are treated as ordinary codes.
- Emit in cycle n (the scan_tick cycle):
  - Modifier flags update at the edge ending cycle n and are visible in cycle n+1. They update regardless of MAKE_EN, BRK_EN, REPEAT_FILT and FIFO state.
  - Each modifier output is the OR of separate left/right flags. Example: shift_dn stays 1 until both 12 and 59 have been released.
  - Enqueue condition: (make & MAKE_EN & !repeat-suppressed) or (break & BRK_EN).
  - If enqueued and FIFO not full: write at the edge ending cycle n; ev_empty=0 in cycle n+1.
  - If enqueued and FIFO full with rd_ev=0: event dropped; ovf_tick pulses in cycle n+1.
  - If FIFO full and rd_ev=1 in the same cycle: read and write both occur, nothing dropped.
- Repeat filter (REPEAT_FILT=1):
  - A make whose {ext,code} equals the stored last make, while the last-make register is valid, is suppressed.
  - Any emitted make updates the stored value and sets it valid, whether or not the make is enqueued.
  - Any break invalidates the register.
- Read: rd_ev with ev_empty=0 advances the head; the new head appears on ev_data in the next cycle. rd_ev with ev_empty=1 has no effect. rd_ev and write on an empty FIFO: the write happens, the read is ignored.
- Pointers wrap modulo 2**FIFO_AW. Full/empty are tracked with explicit registered flags, not pointer equality alone.

Decomposition:
- Shared package kb_pkg holds:
  - Constants: KB_EXT=8'hE0, KB_BRK=8'hF0, KB_LSHIFT=8'h12, KB_RSHIFT=8'h59, KB_CTRL=8'h14, KB_ALT=8'h11.
  - Event-field bit positions.
  - The FSM state encoding (2 bits).
- One sub-module: kb_event_fifo (parametrised width B=10, address width W=FIFO_AW, FWFT, full/empty flags).
- Decode FSM, modifier tracking and repeat filter are implemented in the top.

Test Plan:
- Bytes 1C, F0, 1C (defaults) -> two events: 0x01C (make A), then 0x21C; ev_empty falls one cycle after the first tick.
- Bytes E0 75, E0 F0 75 -> events 0x175 and 0x375; shift_dn, ctrl_dn and alt_dn stay 0.
- Bytes 12, 59, F0 12 -> shift_dn=1 after the first tick; still 1 after F0 12; drops to 0 after F0 59.
- FIFO_AW=2, six make bytes with no reads -> four events held, ev_full=1, ovf_tick pulses twice. A pop on the same cycle as a write while full -> no pulse.
- REPEAT_FILT=1, bytes 1C 1C 1C F0 1C 1C -> events 0x01C, 0x21C, 0x01C only.
- Bytes F0 F0 -> proto_err pulse, no event. Reset asserted after E0 -> next byte 1C produces 0x01C (not extended).
